my_mcpu_ctrl: RTL and testbench
===============================

# my_MCPU_ctrl

Multi-cycle control unit for the RV32I-subset CPU. A Moore-style FSM sequences the shared datapath (one ALU, one memory port, PC/IR/OldPC/ALUOut/MDR registers) through fetch, decode, execute, memory and write-back. It decodes the same opcode subset as the single-cycle controller and stalls on MIO_ready for every memory access. It sits between the instruction register fields and the datapath mux/strobe inputs.

## Interface
- No parameters; encodings come from mcpu_pkg.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- OPcode  in  5  inst[6:2]
- Fun3  in  3  inst[14:12]
- Fun7  in  1  inst[30]
- Zero  in  1  ALU zero flag, same cycle
- MIO_ready  in  1  memory access complete this cycle
- MemReq  out  1  memory access request (CPU_MIO)
- MemRW  out  1  1 = write, qualified by MemReq
- IorD  out  1  address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = ALU result & ~1
- ALUSrc_A  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrc_B  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ALU_Control  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9
- ImmSel  out  3  I 000, S 001, B 010, J 011, U 100
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC, 11 = imm
- RegWrite  out  1  register-file write strobe
- Illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state, for debug

## Operation
Unlisted outputs are 0; ALU_Control defaults to ADD.

- IF (0): MemReq, IorD = 0, A = PC, B = 4, ADD.
  - MIO_ready = 1: IRWrite, PCWrite, PCSource = 00, go to ID.
  - Otherwise stay in IF.
- ID (1): A = OldPC, B = imm, ADD; ImmSel = B for branch, J for jal. ALUOut holds the target.
  - Next state by OPcode: 01100 to EXR, 00100 to EXI, 00000/01000 to EXMA, 11000 to BR, 11011 to JAL, 11001 to JALR, 01101 to LUI.
  - Any other OPcode: go to ERR.
- EXR (2): A = rs1, B = rs2, ALU_Control from Fun3/Fun7, go to WBA.
- EXI (3): A = rs1, B = imm (I), go to WBA.
  - Fun7 is honoured only for Fun3 = 101 (srli/srai); addi never yields SUB.
- EXMA (4): A = rs1, B = imm, ADD.
  - Load: ImmSel = I, go to MRD.
  - Store: ImmSel = S, go to MWR.
- MRD (5): MemReq, IorD = 1, MemRW = 0. Wait for MIO_ready, then go to WBM.
- MWR (6): MemReq, IorD = 1, MemRW = 1. Wait for MIO_ready, then go to IF.
- WBA (7): RegWrite, MemtoReg = 00, go to IF.
- WBM (8): RegWrite, MemtoReg = 01, go to IF.
- BR (9): A = rs1, B = rs2, SUB.
  - PCWrite with PCSource = 01 iff (Fun3 = 000 & Zero) or (Fun3 = 001 & !Zero).
  - Other Fun3 values: not taken.
  - Go to IF.
- JAL (10): RegWrite, MemtoReg = 10 (PC already holds old+4), PCWrite, PCSource = 01, go to IF.
- JALR (11): A = rs1, B = imm (I), ADD, RegWrite, MemtoReg = 10, PCWrite, PCSource = 10, go to IF.
- LUI (12): ImmSel = U, RegWrite, MemtoReg = 11, go to IF.
- ERR (15): Illegal = 1, all strobes 0. Held until rst.

## Timing
- rst asserted: state = IF immediately (asynchronous). While rst = 1, MemReq, MemRW, IRWrite, PCWrite and RegWrite are forced to 0. Illegal = 0 and state = 0.
- Reset mid-instruction abandons it; no partial write strobe is issued.
- All outputs decode combinationally from state. Fun3, Fun7, OPcode and Zero feed only the ALU_Control, ImmSel and PCWrite decode in the current cycle.
- Cycles per instruction with MIO_ready tied to 1:
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch, jal, jalr, lui: 3
- Each wait cycle with MIO_ready = 0 adds one cycle in IF, MRD or MWR. Outputs hold steady while waiting.
- A MIO_ready pulse outside IF, MRD and MWR is ignored.

## Structure
- mcpu_pkg holds:
  - state encodings
  - opcode constants
  - ALU_Control codes
  - ImmSel codes
  - MemtoReg, PCSource and ALUSrc codes
- Sub-module my_ALU_dec: combinational Fun3/Fun7/is_imm to ALU_Control, instantiated in EXR/EXI decode.
- The FSM is the only sequential element: 4-bit state register with asynchronous reset.

## Test plan
- Reset, then add with OPcode = 01100, Fun3 = 000, Fun7 = 0, MIO_ready = 1:
  - states 0, 1, 2, 7, 0
  - ALU_Control = 0 in EXR
  - RegWrite = 1 only in WBA
- sub followed by addi with Fun7 = 1:
  - sub: ALU_Control = 1
  - addi: ALU_Control = 0
  - srai (Fun3 = 101, Fun7 = 1): ALU_Control = 7
- Load with MIO_ready low for 3 cycles in MRD:
  - state stays 5 for 4 cycles with MemReq = 1, IorD = 1, MemRW = 0
  - then WBM with MemtoReg = 01
- beq:
  - Zero = 1: PCWrite = 1, PCSource = 01 in BR
  - Zero = 0: PCWrite = 0
  - bne: the inverse
- jal and jalr:
  - both: RegWrite = 1, MemtoReg = 10
  - jal: PCSource = 01
  - jalr: PCSource = 10
  - both return to IF after 3 cycles
- OPcode = 00101 or 11111:
  - ID goes to ERR, Illegal = 1, no strobes
  - rst pulse mid-MWR: state = 0 and MemReq = 0 asynchronously

Source files
------------

// File: rtl/mcpu_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_pkg
// Shared encodings for the multi-cycle RV32I-subset control unit: FSM state
// codes, opcode constants (inst[6:2]), ALU operation codes, immediate-format
// selects and datapath mux select codes.
// -----------------------------------------------------------------------------
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_EXI  = 4'd3,
        S_EXMA = 4'd4,
        S_MRD  = 4'd5,
        S_MWR  = 4'd6,
        S_WBA  = 4'd7,
        S_WBM  = 4'd8,
        S_BR   = 4'd9,
        S_JAL  = 4'd10,
        S_JALR = 4'd11,
        S_LUI  = 4'd12,
        S_ERR  = 4'd15
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_IMM    = 2'b11;

    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_ALU_EVN = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Only beq (000) and bne (001) are supported; every other Fun3 falls through.
    function automatic logic branch_taken(input logic [2:0] fun3, input logic zero);
        return ((fun3 == 3'b000) && zero) || ((fun3 == 3'b001) && !zero);
    endfunction

endpackage

// File: rtl/my_ALU_dec.sv
// -----------------------------------------------------------------------------
// my_ALU_dec
// Combinational ALU operation decode for R-type and I-type arithmetic.
//   Fun3        in  3  inst[14:12]
//   Fun7        in  1  inst[30]
//   is_imm      in  1  1 = I-type (Fun7 only meaningful for shifts)
//   ALU_Control out 4  operation code from mcpu_pkg
// -----------------------------------------------------------------------------
module my_ALU_dec
    import mcpu_pkg::*;
(
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       is_imm,
    output logic [3:0] ALU_Control
);

    always_comb begin
        ALU_Control = ALU_ADD;
        unique case (Fun3)
            // inst[30] of an addi is immediate data, never a SUB select
            3'b000: ALU_Control = (Fun7 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001: ALU_Control = ALU_SLL;
            3'b010: ALU_Control = ALU_SLT;
            3'b011: ALU_Control = ALU_SLTU;
            3'b100: ALU_Control = ALU_XOR;
            3'b101: ALU_Control = Fun7 ? ALU_SRA : ALU_SRL;
            3'b110: ALU_Control = ALU_OR;
            3'b111: ALU_Control = ALU_AND;
            default: ALU_Control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/my_mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// my_mcpu_ctrl
// Moore FSM that sequences the shared multi-cycle datapath through fetch,
// decode, execute, memory and write-back for the RV32I subset.
//   clk, rst                     clock / async active-high reset
//   OPcode, Fun3, Fun7           instruction register fields
//   Zero                         ALU zero flag (same cycle)
//   MIO_ready                    memory access completes this cycle
//   MemReq, MemRW, IorD          memory port control
//   IRWrite, PCWrite, PCSource   IR/OldPC and PC load control
//   ALUSrc_A, ALUSrc_B,
//   ALU_Control, ImmSel          ALU operand/operation select
//   MemtoReg, RegWrite           register-file write-back control
//   Illegal                      sticky unsupported-opcode flag
//   state                        current state (debug)
//
// state | meaning
// ------+---------------------------------------------------------
// IF    | fetch at PC, PC <= PC+4, wait on MIO_ready
// ID    | decode; ALUOut <= OldPC + imm (branch/jal target)
// EXR   | R-type ALU op
// EXI   | I-type ALU op
// EXMA  | load/store address = rs1 + imm
// MRD   | memory read, wait on MIO_ready
// MWR   | memory write, wait on MIO_ready
// WBA   | write ALUOut to rd
// WBM   | write MDR to rd
// BR    | compare rs1/rs2, PC <= ALUOut if taken
// JAL   | rd <= PC, PC <= ALUOut
// JALR  | rd <= PC, PC <= (rs1 + imm) & ~1
// LUI   | rd <= U-immediate
// ERR   | unsupported opcode, held until reset
// -----------------------------------------------------------------------------
module my_mcpu_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       Zero,
    input  logic       MIO_ready,
    output logic       MemReq,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [3:0] ALU_Control,
    output logic [2:0] ImmSel,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] alu_dec;
    logic       mem_req_raw;
    logic       mem_rw_raw;
    logic       ir_write_raw;
    logic       pc_write_raw;
    logic       reg_write_raw;

    my_ALU_dec u_alu_dec (
        .Fun3        (Fun3),
        .Fun7        (Fun7),
        .is_imm      (state_q == S_EXI),
        .ALU_Control (alu_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_raw   = 1'b0;
        mem_rw_raw    = 1'b0;
        IorD          = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        PCSource      = PCS_ALU;
        ALUSrc_A      = SRCA_PC;
        ALUSrc_B      = SRCB_RS2;
        ALU_Control   = ALU_ADD;
        ImmSel        = IMM_I;
        MemtoReg      = M2R_ALUOUT;
        reg_write_raw = 1'b0;
        Illegal       = 1'b0;

        unique case (state_q)
            S_IF: begin
                mem_req_raw = 1'b1;
                ALUSrc_A    = SRCA_PC;
                ALUSrc_B    = SRCB_FOUR;
                if (MIO_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    PCSource     = PCS_ALU;
                    state_d      = S_ID;
                end
            end
            S_ID: begin
                ALUSrc_A = SRCA_OLDPC;
                ALUSrc_B = SRCB_IMM;
                if (OPcode == OP_BRANCH) ImmSel = IMM_B;
                else if (OPcode == OP_JAL) ImmSel = IMM_J;
                unique case (OPcode)
                    OP_R:               state_d = S_EXR;
                    OP_I:               state_d = S_EXI;
                    OP_LOAD, OP_STORE:  state_d = S_EXMA;
                    OP_BRANCH:          state_d = S_BR;
                    OP_JAL:             state_d = S_JAL;
                    OP_JALR:            state_d = S_JALR;
                    OP_LUI:             state_d = S_LUI;
                    default:            state_d = S_ERR;
                endcase
            end
            S_EXR: begin
                ALUSrc_A    = SRCA_RS1;
                ALUSrc_B    = SRCB_RS2;
                ALU_Control = alu_dec;
                state_d     = S_WBA;
            end
            S_EXI: begin
                ALUSrc_A    = SRCA_RS1;
                ALUSrc_B    = SRCB_IMM;
                ImmSel      = IMM_I;
                ALU_Control = alu_dec;
                state_d     = S_WBA;
            end
            S_EXMA: begin
                ALUSrc_A = SRCA_RS1;
                ALUSrc_B = SRCB_IMM;
                // ID only routes loads and stores here, so non-load means store
                if (OPcode == OP_LOAD) begin
                    ImmSel  = IMM_I;
                    state_d = S_MRD;
                end else begin
                    ImmSel  = IMM_S;
                    state_d = S_MWR;
                end
            end
            S_MRD: begin
                mem_req_raw = 1'b1;
                IorD        = 1'b1;
                if (MIO_ready) state_d = S_WBM;
            end
            S_MWR: begin
                mem_req_raw = 1'b1;
                mem_rw_raw  = 1'b1;
                IorD        = 1'b1;
                if (MIO_ready) state_d = S_IF;
            end
            S_WBA: begin
                reg_write_raw = 1'b1;
                MemtoReg      = M2R_ALUOUT;
                state_d       = S_IF;
            end
            S_WBM: begin
                reg_write_raw = 1'b1;
                MemtoReg      = M2R_MDR;
                state_d       = S_IF;
            end
            S_BR: begin
                ALUSrc_A    = SRCA_RS1;
                ALUSrc_B    = SRCB_RS2;
                ALU_Control = ALU_SUB;
                if (branch_taken(Fun3, Zero)) begin
                    pc_write_raw = 1'b1;
                    PCSource     = PCS_ALUOUT;
                end
                state_d = S_IF;
            end
            S_JAL: begin
                // PC already advanced to old+4 in IF; ALUOut has the target from ID
                reg_write_raw = 1'b1;
                MemtoReg      = M2R_PC;
                pc_write_raw  = 1'b1;
                PCSource      = PCS_ALUOUT;
                state_d       = S_IF;
            end
            S_JALR: begin
                ALUSrc_A      = SRCA_RS1;
                ALUSrc_B      = SRCB_IMM;
                ImmSel        = IMM_I;
                reg_write_raw = 1'b1;
                MemtoReg      = M2R_PC;
                pc_write_raw  = 1'b1;
                PCSource      = PCS_ALU_EVN;
                state_d       = S_IF;
            end
            S_LUI: begin
                ImmSel        = IMM_U;
                reg_write_raw = 1'b1;
                MemtoReg      = M2R_IMM;
                state_d       = S_IF;
            end
            S_ERR: begin
                Illegal = 1'b1;
                state_d = S_ERR;
            end
            // unused encodings are treated as a fault and parked
            default: begin
                Illegal = 1'b1;
                state_d = S_ERR;
            end
        endcase
    end

    // State is already IF during reset, but IF would otherwise request a fetch
    assign MemReq   = mem_req_raw   & ~rst;
    assign MemRW    = mem_rw_raw    & ~rst;
    assign IRWrite  = ir_write_raw  & ~rst;
    assign PCWrite  = pc_write_raw  & ~rst;
    assign RegWrite = reg_write_raw & ~rst;
    assign state    = state_q;

endmodule

// File: tb/tb_my_mcpu_ctrl.sv
module tb_my_mcpu_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       Zero;
    logic       MIO_ready;
    logic       MemReq;
    logic       MemRW;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [3:0] ALU_Control;
    logic [2:0] ImmSel;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] state;

    my_mcpu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .OPcode      (OPcode),
        .Fun3        (Fun3),
        .Fun7        (Fun7),
        .Zero        (Zero),
        .MIO_ready   (MIO_ready),
        .MemReq      (MemReq),
        .MemRW       (MemRW),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .ALUSrc_A    (ALUSrc_A),
        .ALUSrc_B    (ALUSrc_B),
        .ALU_Control (ALU_Control),
        .ImmSel      (ImmSel),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Illegal     (Illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_STATE = 0;
    localparam int K_MREQ  = 1;
    localparam int K_MRW   = 2;
    localparam int K_IORD  = 3;
    localparam int K_IRW   = 4;
    localparam int K_PCW   = 5;
    localparam int K_PCS   = 6;
    localparam int K_SRCA  = 7;
    localparam int K_SRCB  = 8;
    localparam int K_ALU   = 9;
    localparam int K_IMM   = 10;
    localparam int K_M2R   = 11;
    localparam int K_REGW  = 12;
    localparam int K_ILL   = 13;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            K_STATE: return {28'd0, state};
            K_MREQ:  return {31'd0, MemReq};
            K_MRW:   return {31'd0, MemRW};
            K_IORD:  return {31'd0, IorD};
            K_IRW:   return {31'd0, IRWrite};
            K_PCW:   return {31'd0, PCWrite};
            K_PCS:   return {30'd0, PCSource};
            K_SRCA:  return {30'd0, ALUSrc_A};
            K_SRCB:  return {30'd0, ALUSrc_B};
            K_ALU:   return {28'd0, ALU_Control};
            K_IMM:   return {29'd0, ImmSel};
            K_M2R:   return {30'd0, MemtoReg};
            K_REGW:  return {31'd0, RegWrite};
            K_ILL:   return {31'd0, Illegal};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === 32'(e.val)) else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
            end
        end
    endtask

    // Called at a negedge after inputs are driven: settle, compare, advance one cycle.
    task automatic tick();
        #1;
        check_now();
        @(negedge clk);
    endtask

    task automatic set_inst(input logic [4:0] op, input logic [2:0] f3, input logic f7);
        OPcode = op;
        Fun3   = f3;
        Fun7   = f7;
    endtask

    task automatic do_if(input string tag);
        push({tag, ".if.state"}, K_STATE, 0);
        push({tag, ".if.memreq"}, K_MREQ, 1);
        push({tag, ".if.iord"}, K_IORD, 0);
        push({tag, ".if.irwrite"}, K_IRW, int'(MIO_ready));
        push({tag, ".if.pcwrite"}, K_PCW, int'(MIO_ready));
        push({tag, ".if.pcsrc"}, K_PCS, 0);
        push({tag, ".if.srcb"}, K_SRCB, 2);
        push({tag, ".if.alu"}, K_ALU, 0);
        push({tag, ".if.regwrite"}, K_REGW, 0);
        tick();
    endtask

    task automatic do_id(input string tag, input int imm);
        push({tag, ".id.state"}, K_STATE, 1);
        push({tag, ".id.srca"}, K_SRCA, 1);
        push({tag, ".id.srcb"}, K_SRCB, 1);
        push({tag, ".id.immsel"}, K_IMM, imm);
        push({tag, ".id.memreq"}, K_MREQ, 0);
        push({tag, ".id.pcwrite"}, K_PCW, 0);
        push({tag, ".id.regwrite"}, K_REGW, 0);
        tick();
    endtask

    task automatic do_alu_op(input string tag, input int st, input int srcb, input int alu);
        push({tag, ".ex.state"}, K_STATE, st);
        push({tag, ".ex.srca"}, K_SRCA, 2);
        push({tag, ".ex.srcb"}, K_SRCB, srcb);
        push({tag, ".ex.alu"}, K_ALU, alu);
        push({tag, ".ex.regwrite"}, K_REGW, 0);
        tick();
        push({tag, ".wba.state"}, K_STATE, 7);
        push({tag, ".wba.regwrite"}, K_REGW, 1);
        push({tag, ".wba.memtoreg"}, K_M2R, 0);
        push({tag, ".wba.memreq"}, K_MREQ, 0);
        tick();
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z, input int taken);
        set_inst(5'b11000, f3, 1'b0);
        do_if(tag);
        do_id(tag, 2);
        Zero = z;
        push({tag, ".br.state"}, K_STATE, 9);
        push({tag, ".br.alu"}, K_ALU, 1);
        push({tag, ".br.pcwrite"}, K_PCW, taken);
        if (taken != 0) push({tag, ".br.pcsrc"}, K_PCS, 1);
        push({tag, ".br.regwrite"}, K_REGW, 0);
        tick();
        Zero = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        MIO_ready = 1'b1;
        Zero      = 1'b0;
        set_inst(5'b01100, 3'b000, 1'b0);

        #2;
        push("rst.state", K_STATE, 0);
        push("rst.memreq", K_MREQ, 0);
        push("rst.irwrite", K_IRW, 0);
        push("rst.pcwrite", K_PCW, 0);
        push("rst.illegal", K_ILL, 0);
        check_now();
        @(negedge clk);
        rst = 1'b0;

        // add: 0 -> 1 -> 2 -> 7 -> 0
        do_if("add");
        do_id("add", 0);
        do_alu_op("add", 2, 0, 0);

        // sub, addi with Fun7 set, srai, slt
        set_inst(5'b01100, 3'b000, 1'b1);
        do_if("sub");
        do_id("sub", 0);
        do_alu_op("sub", 2, 0, 1);

        set_inst(5'b00100, 3'b000, 1'b1);
        do_if("addi");
        do_id("addi", 0);
        do_alu_op("addi", 3, 1, 0);

        set_inst(5'b00100, 3'b101, 1'b1);
        do_if("srai");
        do_id("srai", 0);
        do_alu_op("srai", 3, 1, 7);

        set_inst(5'b01100, 3'b010, 1'b0);
        do_if("slt");
        do_id("slt", 0);
        do_alu_op("slt", 2, 0, 3);

        // Fetch stall of one cycle, then load with three MRD wait cycles
        set_inst(5'b00000, 3'b010, 1'b0);
        MIO_ready = 1'b0;
        do_if("lw.stall");
        MIO_ready = 1'b1;
        do_if("lw");
        do_id("lw", 0);
        push("lw.exma.state", K_STATE, 4);
        push("lw.exma.immsel", K_IMM, 0);
        push("lw.exma.srca", K_SRCA, 2);
        push("lw.exma.srcb", K_SRCB, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            MIO_ready = (i == 3);
            push("lw.mrd.state", K_STATE, 5);
            push("lw.mrd.memreq", K_MREQ, 1);
            push("lw.mrd.iord", K_IORD, 1);
            push("lw.mrd.memrw", K_MRW, 0);
            push("lw.mrd.regwrite", K_REGW, 0);
            tick();
        end
        push("lw.wbm.state", K_STATE, 8);
        push("lw.wbm.memtoreg", K_M2R, 1);
        push("lw.wbm.regwrite", K_REGW, 1);
        push("lw.wbm.memreq", K_MREQ, 0);
        tick();
        push("lw.done.state", K_STATE, 0);
        check_now();

        // Store: 4 cycles
        set_inst(5'b01000, 3'b010, 1'b0);
        do_if("sw");
        do_id("sw", 0);
        push("sw.exma.state", K_STATE, 4);
        push("sw.exma.immsel", K_IMM, 1);
        tick();
        push("sw.mwr.state", K_STATE, 6);
        push("sw.mwr.memreq", K_MREQ, 1);
        push("sw.mwr.memrw", K_MRW, 1);
        push("sw.mwr.iord", K_IORD, 1);
        tick();

        // beq / bne / blt (unsupported compare never taken)
        do_branch("beq.z1", 3'b000, 1'b1, 1);
        do_branch("beq.z0", 3'b000, 1'b0, 0);
        do_branch("bne.z0", 3'b001, 1'b0, 1);
        do_branch("bne.z1", 3'b001, 1'b1, 0);
        do_branch("blt.z0", 3'b100, 1'b0, 0);

        // MIO_ready pulse outside IF/MRD/MWR is ignored: BR still goes to IF
        push("br.ret.state", K_STATE, 0);
        check_now();

        // jal
        set_inst(5'b11011, 3'b000, 1'b0);
        do_if("jal");
        do_id("jal", 3);
        push("jal.state", K_STATE, 10);
        push("jal.regwrite", K_REGW, 1);
        push("jal.memtoreg", K_M2R, 2);
        push("jal.pcwrite", K_PCW, 1);
        push("jal.pcsrc", K_PCS, 1);
        tick();
        push("jal.ret.state", K_STATE, 0);
        check_now();

        // jalr
        set_inst(5'b11001, 3'b000, 1'b0);
        do_if("jalr");
        do_id("jalr", 0);
        push("jalr.state", K_STATE, 11);
        push("jalr.regwrite", K_REGW, 1);
        push("jalr.memtoreg", K_M2R, 2);
        push("jalr.pcwrite", K_PCW, 1);
        push("jalr.pcsrc", K_PCS, 2);
        push("jalr.srca", K_SRCA, 2);
        push("jalr.srcb", K_SRCB, 1);
        push("jalr.alu", K_ALU, 0);
        tick();
        push("jalr.ret.state", K_STATE, 0);
        check_now();

        // lui
        set_inst(5'b01101, 3'b000, 1'b0);
        do_if("lui");
        do_id("lui", 0);
        push("lui.state", K_STATE, 12);
        push("lui.immsel", K_IMM, 4);
        push("lui.memtoreg", K_M2R, 3);
        push("lui.regwrite", K_REGW, 1);
        tick();

        // Illegal opcodes: ERR is sticky until reset
        for (int k = 0; k < 2; k++) begin
            set_inst((k == 0) ? 5'b00101 : 5'b11111, 3'b000, 1'b0);
            do_if("ill");
            do_id("ill", 0);
            for (int c = 0; c < 3; c++) begin
                push("ill.state", K_STATE, 15);
                push("ill.illegal", K_ILL, 1);
                push("ill.memreq", K_MREQ, 0);
                push("ill.pcwrite", K_PCW, 0);
                push("ill.regwrite", K_REGW, 0);
                push("ill.irwrite", K_IRW, 0);
                tick();
            end
            #2 rst = 1'b1;
            #1;
            push("ill.rst.state", K_STATE, 0);
            push("ill.rst.illegal", K_ILL, 0);
            push("ill.rst.memreq", K_MREQ, 0);
            check_now();
            @(negedge clk);
            rst = 1'b0;
        end

        // Reset mid-MWR: asynchronous return to IF with no strobe
        set_inst(5'b01000, 3'b000, 1'b0);
        do_if("swr");
        do_id("swr", 0);
        tick();
        MIO_ready = 1'b0;
        push("swr.mwr.state", K_STATE, 6);
        push("swr.mwr.memreq", K_MREQ, 1);
        check_now();
        #1 rst = 1'b1;
        #1;
        push("swr.rst.state", K_STATE, 0);
        push("swr.rst.memreq", K_MREQ, 0);
        push("swr.rst.memrw", K_MRW, 0);
        check_now();
        @(negedge clk);
        MIO_ready = 1'b1;
        rst = 1'b0;
        set_inst(5'b01100, 3'b000, 1'b0);
        do_if("post");
        push("post.id.state", K_STATE, 1);
        check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
